load_unit: RTL and testbench

LOAD_UNIT -- requirements
Module: load_unit

---
 rtl/load_unit_pkg.sv | 30 +++
 rtl/load_extract.sv | 38 +++
 rtl/load_unit.sv | 131 +++++++++++++
 tb/tb_load_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_unit_pkg.sv
// Shared definitions for the load unit: memory opcodes (loads and stores),
// FSM state type and a small opcode classification helper.
package load_unit_pkg;

    // Memory-access opcodes
    localparam logic [5:0] op_LB  = 6'h20;
    localparam logic [5:0] op_LH  = 6'h21;
    localparam logic [5:0] op_LW  = 6'h23;
    localparam logic [5:0] op_LBU = 6'h24;
    localparam logic [5:0] op_LHU = 6'h25;
    localparam logic [5:0] op_SB  = 6'h28;
    localparam logic [5:0] op_SH  = 6'h29;
    localparam logic [5:0] op_SW  = 6'h2B;

    // Load FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } ld_state_t;

    // True for the five opcodes the load unit acts upon
    function automatic logic is_load(input logic [5:0] op);
        return (op == op_LB) || (op == op_LBU) || (op == op_LH) ||
               (op == op_LHU) || (op == op_LW);
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load-data extraction: selects the byte/half/word addressed
// by the captured offset and sign- or zero-extends it to 32 bits.
module load_extract
    import load_unit_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = word[gi*8 +: 8];
        end
    endgenerate

    // Pick the addressed byte/half, then extend according to the opcode
    always_comb begin
        byte_sel = lanes[offset];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        result   = 32'd0;
        case (op)
            op_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            op_LBU:  result = {24'd0, byte_sel};
            op_LH:   result = {{16{half_sel[15]}}, half_sel};
            op_LHU:  result = {16'd0, half_sel};
            op_LW:   result = word;
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// MEM-stage load unit: issues one bus read per load, waits for the data,
// extracts/extends it and presents a one-cycle result. A flush while the
// read is outstanding drains the returning data without producing a result.
// Optional feature: define ADEL_DETECT_EN to flag misaligned loads (adelM)
// and suppress their issue.
module load_unit
    import load_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_validM,
    input  logic [5:0]  opM,
    input  logic [31:0] aluoutM,
    input  logic        flushM,
    output logic        data_req,
    output logic [31:0] data_addr,
    input  logic        data_addr_ok,
    input  logic [31:0] data_rdata,
    input  logic        data_data_ok,
    output logic [31:0] resultM,
    output logic        result_validM,
    output logic        ld_stall,
    output logic        adelM,
    output logic [31:0] badvaddrM
);

    ld_state_t   state_reg;
    logic        data_req_reg;
    logic [31:0] data_addr_reg;
    logic [31:0] result_reg;
    logic        result_valid_reg;
    logic [1:0]  off_reg;
    logic [5:0]  op_reg;

    logic [1:0]  offset;
    logic        load_op;
    logic        issue;
    logic [31:0] extracted;

    assign offset  = aluoutM[1:0];
    assign load_op = is_load(opM);

`ifdef ADEL_DETECT_EN
    // Halfword loads need a[0]=0, word loads need a=0
    assign adelM     = ld_validM & ((((opM == op_LH) | (opM == op_LHU)) & offset[0]) |
                                    ((opM == op_LW) & (offset != 2'd0)));
    assign badvaddrM = adelM ? aluoutM : 32'd0;
`else
    assign adelM     = 1'b0;
    assign badvaddrM = 32'd0;
`endif

    assign issue = (state_reg == ST_IDLE) & ld_validM & load_op & ~flushM & ~adelM;

    // Stall from the issue cycle until the data is back; released in DONE
    assign ld_stall = ~rst & (issue | (state_reg == ST_REQ) |
                              (state_reg == ST_WAIT) | (state_reg == ST_DRAIN));

    assign data_req      = data_req_reg;
    assign data_addr     = data_addr_reg;
    assign resultM       = result_reg;
    assign result_validM = result_valid_reg;

    // Extraction works on the offset/op captured at issue, not the live inputs
    load_extract u_extract (
        .op     (op_reg),
        .offset (off_reg),
        .word   (data_rdata),
        .result (extracted)
    );

    // Load FSM with registered bus request, address and result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            data_req_reg     <= 1'b0;
            data_addr_reg    <= 32'd0;
            result_reg       <= 32'd0;
            result_valid_reg <= 1'b0;
            off_reg          <= 2'd0;
            op_reg           <= 6'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    result_valid_reg <= 1'b0;
                    if (issue) begin
                        state_reg     <= ST_REQ;
                        data_req_reg  <= 1'b1;
                        data_addr_reg <= {aluoutM[31:2], 2'b00};
                        off_reg       <= offset;
                        op_reg        <= opM;
                    end
                end
                ST_REQ: begin
                    // An accepted request must complete, so addr_ok wins over flush
                    if (data_addr_ok) begin
                        state_reg    <= ST_WAIT;
                        data_req_reg <= 1'b0;
                    end else if (flushM) begin
                        state_reg    <= ST_IDLE;
                        data_req_reg <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (data_data_ok) begin
                        state_reg        <= ST_DONE;
                        result_reg       <= extracted;
                        result_valid_reg <= 1'b1;
                    end else if (flushM) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_reg        <= ST_IDLE;
                    result_valid_reg <= 1'b0;
                end
                ST_DRAIN: begin
                    if (data_data_ok) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg        <= ST_IDLE;
                    data_req_reg     <= 1'b0;
                    result_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Testbench for load_unit: directed vector table, hand-written flush/reset
// sequences and randomized loads checked against a transaction-level model.
module tb_load_unit;
    import load_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        ld_validM;
    logic [5:0]  opM;
    logic [31:0] aluoutM;
    logic        flushM;
    logic        data_req;
    logic [31:0] data_addr;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic [31:0] resultM;
    logic        result_validM;
    logic        ld_stall;
    logic        adelM;
    logic [31:0] badvaddrM;

    int n_cmp = 0;
    int n_bad = 0;

    load_unit dut (
        .clk           (clk),
        .rst           (rst),
        .ld_validM     (ld_validM),
        .opM           (opM),
        .aluoutM       (aluoutM),
        .flushM        (flushM),
        .data_req      (data_req),
        .data_addr     (data_addr),
        .data_addr_ok  (data_addr_ok),
        .data_rdata    (data_rdata),
        .data_data_ok  (data_data_ok),
        .resultM       (resultM),
        .result_validM (result_validM),
        .ld_stall      (ld_stall),
        .adelM         (adelM),
        .badvaddrM     (badvaddrM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: shift the word down to the addressed lane
    function automatic logic [31:0] ref_extract(input logic [5:0] op, input logic [31:0] addr,
                                                input logic [31:0] rdata);
        int unsigned b;
        int unsigned h;
        int          r;
        int unsigned lane;
        lane = addr % 4;
        b = (rdata >> (8 * lane)) % 256;
        h = (rdata >> (16 * (lane / 2))) % 65536;
        r = 0;
        if (op == op_LB)       r = (b >= 128) ? int'(b) - 256 : int'(b);
        else if (op == op_LBU) r = int'(b);
        else if (op == op_LH)  r = (h >= 32768) ? int'(h) - 65536 : int'(h);
        else if (op == op_LHU) r = int'(h);
        else if (op == op_LW)  r = int'(rdata);
        return r;
    endfunction

    // One load: addr_ok arrives da cycles after the earliest slot, data_ok dd
    // cycles after its earliest slot; optional flush during the result cycle.
    task automatic run_load(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rdata,
                            input int da, input int dd, input bit fd, input logic [31:0] exp,
                            input string tag);
        int done_c;
        done_c = 3 + da + dd;
        for (int c = 0; c <= done_c + 1; c++) begin
            @(posedge clk); #1;
            ld_validM    = (c <= done_c);
            opM          = op;
            aluoutM      = addr;
            data_addr_ok = (c == 1 + da);
            data_data_ok = (c == 2 + da + dd);
            data_rdata   = (c == 2 + da + dd) ? rdata : $urandom;
            flushM       = fd && (c == done_c);
            @(negedge clk);
            check($sformatf("%s stall c%0d", tag, c), {31'd0, ld_stall}, {31'd0, c <= 2 + da + dd});
            check($sformatf("%s req c%0d", tag, c), {31'd0, data_req}, {31'd0, (c >= 1) && (c <= 1 + da)});
            if ((c >= 1) && (c <= 1 + da))
                check($sformatf("%s addr c%0d", tag, c), data_addr, {addr[31:2], 2'b00});
            check($sformatf("%s rvalid c%0d", tag, c), {31'd0, result_validM}, {31'd0, c == done_c});
            if (c == done_c)
                check($sformatf("%s result", tag), resultM, exp);
        end
        $display("txn %s op=%h addr=%h rdata=%h da=%0d dd=%0d result=%h expected=%h",
                 tag, op, addr, rdata, da, dd, resultM, exp);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          da;
        int          dd;
        bit          fd;
        logic [31:0] exp;
    } vec_t;

    vec_t       vecs [8];
    logic [5:0] ops [5];

    initial begin
        rst = 1'b1; ld_validM = 1'b1; opM = op_LW; aluoutM = 32'h100;
        flushM = 1'b0; data_addr_ok = 1'b0; data_rdata = 32'd0; data_data_ok = 1'b0;

        // Reset state, with a load presented during reset
        #2;
        check("rst data_req", {31'd0, data_req}, 32'd0);
        check("rst data_addr", data_addr, 32'd0);
        check("rst resultM", resultM, 32'd0);
        check("rst rvalid", {31'd0, result_validM}, 32'd0);
        check("rst stall", {31'd0, ld_stall}, 32'd0);
        $display("txn reset checked");
        @(posedge clk); #1;
        ld_validM = 1'b0;
        rst = 1'b0;

        // Directed vectors (entry 2: addr_ok in cycle 5, data_ok 3 cycles later, result cycle 9)
        vecs[0] = '{op_LB,  32'h0000_1003, 32'h80FF_0000, 0, 0, 1'b0, 32'hFFFF_FF80};
        vecs[1] = '{op_LHU, 32'h0000_2002, 32'h8001_1234, 0, 0, 1'b0, 32'h0000_8001};
        vecs[2] = '{op_LW,  32'h0000_3000, 32'h1234_5678, 4, 2, 1'b0, 32'h1234_5678};
        vecs[3] = '{op_LBU, 32'h0000_5001, 32'h1234_8056, 1, 1, 1'b0, 32'h0000_0080};
        vecs[4] = '{op_LH,  32'h0000_6000, 32'h0000_F00D, 0, 1, 1'b1, 32'hFFFF_F00D};
        vecs[5] = '{op_LB,  32'h0000_7000, 32'h0000_007F, 2, 0, 1'b0, 32'h0000_007F};
        vecs[6] = '{op_LW,  32'h0000_8004, 32'hDEAD_BEEF, 0, 3, 1'b0, 32'hDEAD_BEEF};
        vecs[7] = '{op_LH,  32'h0000_6002, 32'h8000_1234, 1, 0, 1'b0, 32'hFFFF_8000};
        for (int i = 0; i < 8; i++)
            run_load(vecs[i].op, vecs[i].addr, vecs[i].rdata, vecs[i].da, vecs[i].dd,
                     vecs[i].fd, vecs[i].exp, $sformatf("vec%0d", i));

        // Non-load opcode with ld_validM high is ignored
        @(posedge clk); #1;
        ld_validM = 1'b1; opM = op_SW; aluoutM = 32'h0000_0040;
        @(negedge clk);
        check("store stall", {31'd0, ld_stall}, 32'd0);
        @(posedge clk); #1;
        ld_validM = 1'b0;
        @(negedge clk);
        check("store req", {31'd0, data_req}, 32'd0);
        $display("txn store opcode ignored");

        // Flush in IDLE blocks issue
        @(posedge clk); #1;
        ld_validM = 1'b1; opM = op_LW; aluoutM = 32'h0000_0080; flushM = 1'b1;
        @(negedge clk);
        check("idle flush stall", {31'd0, ld_stall}, 32'd0);
        @(posedge clk); #1;
        ld_validM = 1'b0; flushM = 1'b0;
        @(negedge clk);
        check("idle flush req", {31'd0, data_req}, 32'd0);
        $display("txn flush in idle");

        // Flush in REQ withdraws the request
        @(posedge clk); #1;
        ld_validM = 1'b1; opM = op_LW; aluoutM = 32'h0000_0C00;
        @(posedge clk); #1;
        flushM = 1'b1; ld_validM = 1'b0;
        @(negedge clk);
        check("reqflush req c1", {31'd0, data_req}, 32'd1);
        @(posedge clk); #1;
        flushM = 1'b0;
        @(negedge clk);
        check("reqflush req c2", {31'd0, data_req}, 32'd0);
        check("reqflush stall c2", {31'd0, ld_stall}, 32'd0);
        $display("txn flush in REQ");

        // Flush in WAIT, data returns 2 cycles later and is drained
        @(posedge clk); #1;
        ld_validM = 1'b1; opM = op_LW; aluoutM = 32'h0000_9000;
        @(posedge clk); #1;
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0; flushM = 1'b1; ld_validM = 1'b0;
        @(negedge clk);
        check("drain stall c2", {31'd0, ld_stall}, 32'd1);
        @(posedge clk); #1;
        flushM = 1'b0;
        @(negedge clk);
        check("drain stall c3", {31'd0, ld_stall}, 32'd1);
        check("drain req c3", {31'd0, data_req}, 32'd0);
        @(posedge clk); #1;
        data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("drain stall c4", {31'd0, ld_stall}, 32'd1);
        check("drain rvalid c4", {31'd0, result_validM}, 32'd0);
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        @(negedge clk);
        check("drain stall c5", {31'd0, ld_stall}, 32'd0);
        check("drain rvalid c5", {31'd0, result_validM}, 32'd0);
        $display("txn flush in WAIT drained");
        run_load(op_LBU, 32'h0000_9003, 32'hA5_00_00_00, 0, 0, 1'b0, 32'h0000_00A5, "after_drain");

        // Misaligned halfword
`ifdef ADEL_DETECT_EN
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            ld_validM = 1'b1; opM = op_LH; aluoutM = 32'h0000_4001;
            @(negedge clk);
            check($sformatf("adel c%0d", c), {31'd0, adelM}, 32'd1);
            check($sformatf("badvaddr c%0d", c), badvaddrM, 32'h0000_4001);
            check($sformatf("adel req c%0d", c), {31'd0, data_req}, 32'd0);
            check($sformatf("adel stall c%0d", c), {31'd0, ld_stall}, 32'd0);
        end
        aluoutM = 32'h0000_4002;
        #1;
        check("aligned adel", {31'd0, adelM}, 32'd0);
        check("aligned badvaddr", badvaddrM, 32'd0);
        @(posedge clk); #1;
        ld_validM = 1'b0;
        $display("txn misaligned LH flagged");
`else
        @(posedge clk); #1;
        ld_validM = 1'b1; opM = op_LW; aluoutM = 32'h0000_4003;
        #1;
        check("adel tied", {31'd0, adelM}, 32'd0);
        check("badvaddr tied", badvaddrM, 32'd0);
        ld_validM = 1'b0;
        run_load(op_LH, 32'h0000_4003, 32'hABCD_1234, 0, 0, 1'b0, 32'hFFFF_ABCD, "mis_lh");
`endif

        // Randomized loads against the model
        ops[0] = op_LB; ops[1] = op_LBU; ops[2] = op_LH; ops[3] = op_LHU; ops[4] = op_LW;
        for (int i = 0; i < 40; i++) begin
            logic [5:0]  rop;
            logic [31:0] raddr;
            logic [31:0] rdat;
            rop   = ops[$urandom_range(0, 4)];
            raddr = $urandom;
            rdat  = $urandom;
`ifdef ADEL_DETECT_EN
            if (rop == op_LH || rop == op_LHU) raddr[0] = 1'b0;
            if (rop == op_LW) raddr[1:0] = 2'b00;
`endif
            run_load(rop, raddr, rdat, $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), ref_extract(rop, raddr, rdat),
                     $sformatf("rnd%0d", i));
        end

        // Asynchronous reset while in REQ
        @(posedge clk); #1;
        ld_validM = 1'b1; opM = op_LW; aluoutM = 32'h0000_A000;
        @(negedge clk);
        check("rstreq stall c0", {31'd0, ld_stall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstreq req c1", {31'd0, data_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstreq data_req", {31'd0, data_req}, 32'd0);
        check("rstreq data_addr", data_addr, 32'd0);
        check("rstreq resultM", resultM, 32'd0);
        check("rstreq rvalid", {31'd0, result_validM}, 32'd0);
        check("rstreq stall", {31'd0, ld_stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; ld_validM = 1'b0;
        @(negedge clk);
        check("rstreq idle req", {31'd0, data_req}, 32'd0);
        check("rstreq idle stall", {31'd0, ld_stall}, 32'd0);
        $display("txn reset during REQ");
        run_load(op_LW, 32'h0000_B000, 32'h0BAD_F00D, 0, 0, 1'b0, 32'h0BAD_F00D, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
